// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the memory-game datapath: clears, steps and compares 16 moves.
// Optional macro TIMEOUT_EN adds a move timeout of TIMEOUT_CYCLES cycles in ESPERA.
module exp4_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARACAO  = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTO  = 4'b1010,
    FIM_ERRO    = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } estado_t;

  estado_t estado_reg;
  estado_t estado_next;
  logic    expirou;

`ifdef TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] ciclos_reg;

  // Held at zero outside ESPERA, so every entry into ESPERA starts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ciclos_reg <= '0;
    end else if (estado_reg != ESPERA) begin
      ciclos_reg <= '0;
    end else begin
      ciclos_reg <= ciclos_reg + 1'b1;
    end
  end

  assign expirou = (ciclos_reg == TO_LAST);
`else
  localparam bit TO_ON = 1'b0;

  assign expirou = 1'b0;

  // TIMEOUT_CYCLES only has an effect with the timeout build.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_out_of_range
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg <= INICIAL;
    end else begin
      estado_reg <= estado_next;
    end
  end

  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      INICIAL: begin
        if (iniciar) estado_next = PREPARACAO;
      end
      PREPARACAO: begin
        estado_next = ESPERA;
      end
      ESPERA: begin
        // A move arriving in the last allowed cycle beats the timeout.
        if (jogada_feita) begin
          estado_next = REGISTRA;
        end else if (expirou) begin
          estado_next = FIM_TIMEOUT;
        end
      end
      REGISTRA: begin
        estado_next = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual) begin
          estado_next = FIM_ERRO;
        end else if (fimC) begin
          estado_next = FIM_ACERTO;
        end else begin
          estado_next = PROXIMO;
        end
      end
      PROXIMO: begin
        estado_next = ESPERA;
      end
      FIM_ACERTO, FIM_ERRO: begin
        if (iniciar) estado_next = PREPARACAO;
      end
      FIM_TIMEOUT: begin
        if (!TO_ON) begin
          estado_next = INICIAL;
        end else if (iniciar) begin
          estado_next = PREPARACAO;
        end
      end
      default: begin
        estado_next = INICIAL;
      end
    endcase
  end

  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    case (estado_reg)
      PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA: registraR = 1'b1;
      PROXIMO:  contaC    = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = TO_ON;
        timeout = TO_ON;
      end
      default: begin
      end
    endcase
  end

  assign db_estado = estado_reg;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Randomised game-level bench for exp4_unidade_controle with a behavioural datapath model.
// Define TIMEOUT_EN together with the RTL to exercise the timeout build (TIMEOUT_CYCLES=8).
module tb_exp4_unidade_controle;

`ifdef TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 5000;
`endif

  localparam logic [3:0] S_INI  = 4'b0000;
  localparam logic [3:0] S_PREP = 4'b0001;
  localparam logic [3:0] S_ESP  = 4'b0010;
  localparam logic [3:0] S_REG  = 4'b0100;
  localparam logic [3:0] S_PROX = 4'b0110;
  localparam logic [3:0] S_ACE  = 4'b1010;
  localparam logic [3:0] S_ERR  = 4'b1110;
  localparam logic [3:0] S_TO   = 4'b1101;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, igual, fimC;
  logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  exp4_unidade_controle #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural datapath: address counter, ROM match decided by the planned miss address.
  logic [4:0] addr = 5'd0;
  int miss_addr = 16;
  always @(posedge clock) begin
    if (zeraC) addr <= 5'd0;
    else if (contaC) addr <= addr + 5'd1;
  end
  assign igual = (int'(addr) != miss_addr);
  assign fimC  = (addr == 5'd15);

  // Pulse counters and width monitor.
  int cnt_zc = 0, cnt_zr = 0, cnt_cc = 0, cnt_rr = 0, wide = 0;
  logic p_zc = 0, p_zr = 0, p_cc = 0, p_rr = 0;
  always @(posedge clock) begin
    if (zeraC) cnt_zc <= cnt_zc + 1;
    if (zeraR) cnt_zr <= cnt_zr + 1;
    if (contaC) cnt_cc <= cnt_cc + 1;
    if (registraR) cnt_rr <= cnt_rr + 1;
    if ((zeraC && p_zc) || (zeraR && p_zr) || (contaC && p_cc) || (registraR && p_rr))
      wide <= wide + 1;
    p_zc <= zeraC;
    p_zr <= zeraR;
    p_cc <= contaC;
    p_rr <= registraR;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
    for (int i = 0; i < budget && db_estado != code; i++) tick();
    check(tag, 32'(db_estado), 32'(code));
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick();
    check("prep_state", 32'(db_estado), 32'(S_PREP));
    check("prep_zera", 32'({zeraC, zeraR}), 32'd3);
    iniciar = 1'b0;
    tick();
    check("espera_state", 32'(db_estado), 32'(S_ESP));
    check("zera_one_cycle", 32'({zeraC, zeraR}), 32'd0);
  endtask

  task automatic play_game(input int miss);
    int zc0, cc0, rr0, w0, nmoves, idle, stray;
    logic si;
    miss_addr = miss;
    zc0 = cnt_zc;
    w0  = wide;
    start_game();
    cc0 = cnt_cc;
    rr0 = cnt_rr;
    nmoves = (miss < 16) ? miss + 1 : 16;
    for (int m = 0; m < nmoves; m++) begin
      wait_state("wait_espera", S_ESP, 20);
      idle = int'($urandom % 5);
      for (int k = 0; k < idle; k++) tick();
      jogada_feita = 1'b1;
      tick();
      check("registra", 32'({db_estado, registraR}), 32'({S_REG, 1'b1}));
      // Stray move / start requests while the move is being processed.
      stray = int'($urandom % 4);
      si = 1'($urandom % 2);
      iniciar = si;
      for (int k = 0; k < stray; k++) begin
        tick();
        if (k == 1) iniciar = 1'b0;
      end
      jogada_feita = 1'b0;
      iniciar = 1'b0;
    end
    for (int i = 0; i < 10 && !pronto; i++) tick();
    if (miss < 16) begin
      check("end_state", 32'(db_estado), 32'(S_ERR));
      check("end_flags", 32'({pronto, acertou, errou, timeout}), 32'b1010);
      check("contaC_pulses", 32'(cnt_cc - cc0), 32'(miss));
      check("registraR_pulses", 32'(cnt_rr - rr0), 32'(miss + 1));
    end else begin
      check("end_state", 32'(db_estado), 32'(S_ACE));
      check("end_flags", 32'({pronto, acertou, errou, timeout}), 32'b1100);
      check("contaC_pulses", 32'(cnt_cc - cc0), 32'd15);
      check("registraR_pulses", 32'(cnt_rr - rr0), 32'd16);
    end
    check("zeraC_pulses", 32'(cnt_zc - zc0), 32'd1);
    check("pulse_width", 32'(wide - w0), 32'd0);
    tick();
    tick();
    check("fim_hold", 32'(db_estado), (miss < 16) ? 32'(S_ERR) : 32'(S_ACE));
    $display("game miss_addr=%0d state=%b pronto=%0d acertou=%0d errou=%0d", miss, db_estado, pronto, acertou, errou);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cc0;
    reset = 1'b1;
    iniciar = 1'b0;
    jogada_feita = 1'b0;
    #3;
    check("reset_state", 32'(db_estado), 32'(S_INI));
    check("reset_outputs", 32'({zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}), 32'd0);
    tick();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_state", 32'(db_estado), 32'(S_INI));
    end

    play_game(16);
    play_game(2);
    for (int g = 0; g < 10; g++) begin
      play_game(($urandom % 2) ? 16 : int'($urandom_range(0, 15)));
    end

    // Asynchronous reset while contaC is asserted.
    start_game();
    miss_addr = 16;
    wait_state("ar_espera", S_ESP, 20);
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    wait_state("ar_proximo", S_PROX, 5);
    check("ar_contaC_before", 32'(contaC), 32'd1);
    cc0 = cnt_cc;
    #2;
    reset = 1'b1;
    #1;
    check("ar_state", 32'(db_estado), 32'(S_INI));
    check("ar_outputs", 32'({zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_after", 32'(db_estado), 32'(S_INI));
    check("ar_no_count", 32'(cnt_cc - cc0), 32'd0);
    $display("async reset mid-game state=%b", db_estado);

`ifdef TIMEOUT_EN
    start_game();
    for (int i = 0; i < TO - 1; i++) tick();
    check("to_last_cycle", 32'(db_estado), 32'(S_ESP));
    tick();
    check("to_state", 32'(db_estado), 32'(S_TO));
    check("to_flags", 32'({pronto, acertou, errou, timeout}), 32'b1001);
    $display("timeout after %0d cycles state=%b", TO, db_estado);
    start_game();
    for (int i = 0; i < TO - 1; i++) tick();
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    check("to_move_wins", 32'(db_estado), 32'(S_REG));
    $display("move in last cycle state=%b", db_estado);
`else
    start_game();
    for (int i = 0; i < 100; i++) tick();
    check("no_to_state", 32'(db_estado), 32'(S_ESP));
    check("no_to_flag", 32'({pronto, timeout}), 32'd0);
    $display("100 idle cycles in ESPERA state=%b timeout=%0d", db_estado, timeout);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exp4_unidade_controle.md
Name: exp4_unidade_controle

Overview:
- Moore control unit that sequences the memory-game datapath.
- Drives the datapath control inputs: zeraC, contaC, zeraR, registraR.
- Consumes the datapath status outputs: igual, fimC, jogada_feita.
- Steps through 16 ROM positions, registers one player move per position, compares it against the stored value, and reports hit, miss or timeout.
- Sits beside the datapath in the experiment top level.

Parameters:
- TIMEOUT_CYCLES, 5000: clock cycles allowed in ESPERA before timeout. Used only when TIMEOUT_EN is defined; must be ≥ 2.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces INICIAL immediately.
- iniciar  input  1  start request, level-sampled.
- jogada_feita  input  1  one-cycle pulse from the datapath: a new move is on chaves.
- igual  input  1  registered move equals the ROM word at the current address.
- fimC  input  1  address counter is at 15 (last position).
- zeraC  output  1  clear address counter.
- contaC  output  1  increment address counter.
- zeraR  output  1  clear move register.
- registraR  output  1  load move register from chaves.
- pronto  output  1  game finished, in any terminal state.
- acertou  output  1  all 16 moves matched.
- errou  output  1  a move mismatched.
- timeout  output  1  move not made in time; constant 0 without TIMEOUT_EN.
- db_estado  output  4  current state encoding, for the debug display.

Behaviour:
- State register is 4 bits. All outputs are decoded purely from the registered state (Moore); no input-to-output combinational path.
- Reset: asynchronous. State goes to INICIAL (0000) without waiting for a clock edge; every output is 0 and db_estado is 0000. Reset asserted mid-game abandons the game with no further counter or register pulses.
- States, encodings, asserted outputs and transitions:
  - INICIAL 0000: no outputs. iniciar=1 → PREPARACAO; else stay.
  - PREPARACAO 0001: zeraC=1, zeraR=1. Always → ESPERA.
  - ESPERA 0010: no outputs. jogada_feita=1 → REGISTRA; else stay. With TIMEOUT_EN, a timeout may end this state (see Optional Feature).
  - REGISTRA 0100: registraR=1. Always → COMPARACAO.
  - COMPARACAO 0101: no outputs. Evaluated in priority order:
    - igual=0 → FIM_ERRO.
    - igual=1 and fimC=1 → FIM_ACERTO.
    - igual=1 and fimC=0 → PROXIMO.
  - PROXIMO 0110: contaC=1. Always → ESPERA.
  - FIM_ACERTO 1010: pronto=1, acertou=1.
  - FIM_ERRO 1110: pronto=1, errou=1.
  - FIM_TIMEOUT 1101: pronto=1, timeout=1.
  - All FIM_* states: iniciar=1 → PREPARACAO (restart, which clears counter and register); else hold.
  - Unused encodings → INICIAL on the next edge.
- Each control pulse (zeraC, zeraR, registraR, contaC) is exactly one cycle wide per visit to its state.
- Latency:
  - iniciar to first cycle in ESPERA: 2 edges.
  - jogada_feita to compare decision: REGISTRA (1 cycle), then COMPARACAO (1 cycle).
  - COMPARACAO samples igual one cycle after the register load, so the registered move is already visible.
  - Minimum per-move loop, ESPERA→REGISTRA→COMPARACAO→PROXIMO→ESPERA: 4 cycles.
- iniciar is ignored in every state other than INICIAL and the FIM_* states.
- jogada_feita is ignored outside ESPERA. A pulse arriving in REGISTRA, COMPARACAO or PROXIMO is lost, not queued.

Optional Feature:
- Macro: TIMEOUT_EN.
- Defined:
  - Adds a cycle counter of width clog2(TIMEOUT_CYCLES), cleared on every entry into ESPERA and incremented each cycle spent in ESPERA.
  - When the counter equals TIMEOUT_CYCLES-1 and jogada_feita=0, next state is FIM_TIMEOUT.
  - If jogada_feita=1 in that same cycle, the move wins and next state is REGISTRA.
  - Reset clears the counter asynchronously.
- Not defined: no counter logic is present, timeout is tied to 0, and FIM_TIMEOUT is unreachable (treated as an unused encoding).

Test Plan:
- Reset/idle: reset=1 asserted between edges → db_estado=0000 immediately, all outputs 0. Release reset, hold iniciar=0 for 10 cycles → stays 0000.
- Full hit: iniciar pulse → zeraC=zeraR=1 for one cycle. Then 16 moves with igual=1, fimC=1 only on the 16th → 15 contaC pulses, 16 registraR pulses, final db_estado=1010, pronto=acertou=1.
- Miss at move 3: igual=0 at the third COMPARACAO → db_estado=1110, errou=1, exactly 2 contaC pulses seen. Then iniciar=1 → PREPARACAO, zeraC=1.
- Stray pulses: jogada_feita held 1 during REGISTRA/COMPARACAO/PROXIMO → no extra registraR. iniciar=1 mid-game → no zeraC.
- Async reset mid-game: reset pulsed while in PROXIMO → contaC drops without a clock edge, db_estado=0000.
- TIMEOUT_EN with TIMEOUT_CYCLES=8:
  - No move → FIM_TIMEOUT (1101) after 8 cycles in ESPERA, timeout=1, pronto=1.
  - jogada_feita in the 8th cycle → REGISTRA instead.
  - Without the macro, timeout stays 0 after 100 idle cycles in ESPERA.
